// File: rtl/heater_pkg.sv
// Shared constants for the heater PWM block: register map and CTRL bit positions.
package heater_pkg;

   localparam int unsigned ADDR_W = 3;
   localparam int unsigned DATA_W = 32;

   localparam logic [ADDR_W-1:0] ADDR_CTRL     = 3'd0;
   localparam logic [ADDR_W-1:0] ADDR_PERIOD   = 3'd1;
   localparam logic [ADDR_W-1:0] ADDR_PRESCALE = 3'd2;
   localparam logic [ADDR_W-1:0] ADDR_WDT_LOAD = 3'd3;
   localparam logic [ADDR_W-1:0] ADDR_DUTY0    = 3'd4;
   localparam logic [ADDR_W-1:0] ADDR_STATUS   = 3'd6;

   localparam int unsigned CTRL_EN      = 0;
   localparam int unsigned CTRL_KICK    = 1;
   localparam int unsigned CTRL_TRIPCLR = 2;

endpackage

// File: rtl/heater_pwm_ch.sv
// One heater channel: shadowed active duty, compare against the shared period count, output flop.
module heater_pwm_ch #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic             wrap,
   input  logic             tripped,
   input  logic [CNT_W-1:0] pwm_cnt,
   input  logic [CNT_W-1:0] duty_req,
   output logic             heater_out
);

   logic [CNT_W-1:0] duty_act;
   logic             on_c;

   assign on_c = (pwm_cnt < duty_act);

   // Duty only changes at a period boundary (or while disabled) so a period is never cut short.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         duty_act   <= '0;
         heater_out <= 1'b0;
      end else begin
         if (!en || wrap) begin
            duty_act <= duty_req;
         end
         heater_out <= en & ~tripped & on_c;
      end
   end

endmodule

// File: rtl/soc_system_heater_pwm.sv
// Avalon-MM heater PWM generator with shared prescaler/period counter and a CPU-kicked watchdog.
module soc_system_heater_pwm
   import heater_pkg::*;
#(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned CNT_W  = 16,
   parameter int unsigned WDT_W  = 24
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] address,
   input  logic              write,
   input  logic [DATA_W-1:0] writedata,
   input  logic              read,
   output logic [DATA_W-1:0] readdata,
   output logic [NUM_CH-1:0] heater_out,
   output logic              wdt_tripped
);

   logic             en;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] prescale;
   logic [WDT_W-1:0] wdt_load;
   logic [CNT_W-1:0] duty_req [NUM_CH];
   logic [CNT_W-1:0] pre_cnt;
   logic [CNT_W-1:0] pwm_cnt;
   logic [WDT_W-1:0] wdt_cnt;

   logic              wr_ctrl_c;
   logic              wr_wdt_c;
   logic              kick_c;
   logic              tripclr_c;
   logic              tick_c;
   logic              wrap_c;
   logic              reload_c;
   logic [WDT_W-1:0]  reload_val_c;
   logic [WDT_W-1:0]  wdt_next_c;
   logic              trip_evt_c;
   logic [DATA_W-1:0] rd_c;
   logic              unused_c;

   assign unused_c  = ^{read, writedata[DATA_W-1:WDT_W]};

   assign wr_ctrl_c = write && (address == ADDR_CTRL);
   assign wr_wdt_c  = write && (address == ADDR_WDT_LOAD);
   assign kick_c    = wr_ctrl_c && writedata[CTRL_KICK];
   assign tripclr_c = wr_ctrl_c && writedata[CTRL_TRIPCLR];

   // >= keeps the counters bounded when PRESCALE/PERIOD is lowered below the running count.
   assign tick_c = en && (pre_cnt >= prescale);
   assign wrap_c = tick_c && (pwm_cnt >= period);

   // Configuration registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         en       <= 1'b0;
         period   <= '0;
         prescale <= '0;
         wdt_load <= '0;
      end else if (write) begin
         case (address)
            ADDR_CTRL:     en       <= writedata[CTRL_EN];
            ADDR_PERIOD:   period   <= writedata[CNT_W-1:0];
            ADDR_PRESCALE: prescale <= writedata[CNT_W-1:0];
            ADDR_WDT_LOAD: wdt_load <= writedata[WDT_W-1:0];
            default: ;
         endcase
      end
   end

   // Prescaler and period counter, both parked at 0 while disabled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_cnt <= '0;
         pwm_cnt <= '0;
      end else if (!en) begin
         pre_cnt <= '0;
         pwm_cnt <= '0;
      end else if (tick_c) begin
         pre_cnt <= '0;
         pwm_cnt <= wrap_c ? '0 : pwm_cnt + CNT_W'(1);
      end else begin
         pre_cnt <= pre_cnt + CNT_W'(1);
      end
   end

   // Watchdog next state: reload on kick/clear/load write, otherwise count down to a trip.
   always_comb begin
      wdt_next_c   = wdt_cnt;
      trip_evt_c   = 1'b0;
      reload_c     = kick_c || tripclr_c || wr_wdt_c;
      reload_val_c = wr_wdt_c ? writedata[WDT_W-1:0] : wdt_load;
      if (reload_c) begin
         wdt_next_c = reload_val_c;
      end else if (wdt_load == '0) begin
         wdt_next_c = '0;
      end else if (wdt_cnt != '0) begin
         wdt_next_c = wdt_cnt - WDT_W'(1);
         trip_evt_c = (wdt_cnt == WDT_W'(1));
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wdt_cnt     <= '0;
         wdt_tripped <= 1'b0;
      end else begin
         wdt_cnt <= wdt_next_c;
         if (tripclr_c) begin
            wdt_tripped <= 1'b0;
         end else if (trip_evt_c) begin
            wdt_tripped <= 1'b1;
         end
      end
   end

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      localparam logic [ADDR_W-1:0] DUTY_ADDR = ADDR_DUTY0 + ADDR_W'(ch);

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            duty_req[ch] <= '0;
         end else if (write && (address == DUTY_ADDR)) begin
            duty_req[ch] <= writedata[CNT_W-1:0];
         end
      end

      heater_pwm_ch #(
         .CNT_W(CNT_W)
      ) u_ch (
         .clk       (clk),
         .reset_n   (reset_n),
         .en        (en),
         .wrap      (wrap_c),
         .tripped   (wdt_tripped),
         .pwm_cnt   (pwm_cnt),
         .duty_req  (duty_req[ch]),
         .heater_out(heater_out[ch])
      );
   end

   // Read mux; unimplemented DUTY slots and the reserved address read 0.
   always_comb begin
      rd_c = '0;
      case (address)
         ADDR_CTRL:     rd_c = DATA_W'(en);
         ADDR_PERIOD:   rd_c = DATA_W'(period);
         ADDR_PRESCALE: rd_c = DATA_W'(prescale);
         ADDR_WDT_LOAD: rd_c = DATA_W'(wdt_load);
         ADDR_STATUS:   rd_c = DATA_W'({heater_out, wdt_tripped});
         default: begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (address == ADDR_DUTY0 + ADDR_W'(i)) begin
                  rd_c = DATA_W'(duty_req[i]);
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= '0;
      end else begin
         readdata <= rd_c;
      end
   end

endmodule
